// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak constants, rho offset table and rho FSM state type
package keccak_pkg;
  localparam int NUM_LANES = 25;
  localparam int RHO_OFFSETS [0:24] = '{
    0, 1, 190, 28, 91, 36, 300, 6, 55, 276, 3, 10, 171, 153, 231,
    105, 45, 15, 21, 136, 210, 66, 253, 120, 78
  };
  typedef enum logic [1:0] {IDLE, ROT, DONE} rho_state_t;
  function automatic int rho_rot(input int i, input int w);
    return RHO_OFFSETS[i] % w;
  endfunction
endpackage

// File: rtl/keccak_lane_rot.sv
// keccak_lane_rot: combinational rotation of one lane; bit j=0 is the lane MSB, dir_i=1 rotates backwards
module keccak_lane_rot #(
  parameter int W = 64,
  parameter int AW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  lane_i,
  input  logic [AW-1:0] amt_i,
  input  logic          dir_i,
  output logic [W-1:0]  lane_o
);
  logic [AW-1:0] sh;
  always_comb begin
    sh = dir_i ? AW'((W - int'(amt_i)) % W) : amt_i;
    lane_o = W'({lane_i, lane_i} >> sh);
  end
endmodule

// File: rtl/keccak_rho_seq.sv
// keccak_rho_seq: handshaked Keccak rho step rotating LANES_PER_CYC lanes per clock
// Defining KECCAK_RHO_INV_EN adds port inv, latched on accept, selecting inverse rho.
module keccak_rho_seq
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int LANES_PER_CYC = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef KECCAK_RHO_INV_EN
  input  logic                          inv,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:NUM_LANES*LANE_W-1]   in_state,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:NUM_LANES*LANE_W-1]   out_state
);
  localparam int NCYC = NUM_LANES / LANES_PER_CYC;
  localparam int CW = NCYC > 1 ? $clog2(NCYC) : 1;
  localparam int AW = LANE_W > 1 ? $clog2(LANE_W) : 1;
  localparam int SW = NUM_LANES * LANE_W;
  rho_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [0:SW-1] work_q, work_d;
  logic [LANE_W-1:0] lane_in [LANES_PER_CYC];
  logic [LANE_W-1:0] lane_out [LANES_PER_CYC];
  logic [AW-1:0] amt [LANES_PER_CYC];
  logic dir, accept, last;
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign out_state = work_q;
  assign last = cnt_q == CW'(NCYC - 1);
`ifdef KECCAK_RHO_INV_EN
  logic inv_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  assign dir = inv_q;
`else
  assign dir = 1'b0;
`endif
  always_comb begin
    for (int k = 0; k < LANES_PER_CYC; k++) begin
      lane_in[k] = work_q[(int'(cnt_q) * LANES_PER_CYC + k) * LANE_W +: LANE_W];
      amt[k] = AW'(rho_rot(int'(cnt_q) * LANES_PER_CYC + k, LANE_W));
    end
  end
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < LANES_PER_CYC; k++)
      work_d[(int'(cnt_q) * LANES_PER_CYC + k) * LANE_W +: LANE_W] = lane_out[k];
  end
  for (genvar k = 0; k < LANES_PER_CYC; k++) begin : g_rot
    keccak_lane_rot #(.W(LANE_W), .AW(AW)) u_rot (
      .lane_i(lane_in[k]),
      .amt_i (amt[k]),
      .dir_i (dir),
      .lane_o(lane_out[k])
    );
  end
  // DONE with out_ready and in_valid re-captures directly, giving back-to-back throughput
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      work_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            work_q <= in_state;
            cnt_q <= '0;
            state_q <= ROT;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        ROT: begin
          work_q <= work_d;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          state_q <= last ? DONE : ROT;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_keccak_rho_seq.sv
// tb_keccak_rho_seq: randomized self-checking bench for keccak_rho_seq over several LANE_W/LANES_PER_CYC builds
module tb_keccak_rho_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv [5];
  logic ordy [5];
  logic ivs [5];
  logic ir [5];
  logic ov [5];
  logic [0:1599] si [5];
  logic [0:1599] o [5];
  logic [0:1599] oa, ob, oc;
  logic [0:199] od;
  logic [0:799] oe;
  int checks = 0;
  int errors = 0;
  int WD [5] = '{64, 64, 64, 8, 32};
  int LP [5] = '{5, 25, 1, 5, 5};
  int R [25] = '{0, 1, 190, 28, 91, 36, 300, 6, 55, 276, 3, 10, 171, 153, 231,
                 105, 45, 15, 21, 136, 210, 66, 253, 120, 78};

  always #5 clk = ~clk;

  always_comb begin
    o[0] = oa;
    o[1] = ob;
    o[2] = oc;
    o[3] = {od, 1400'b0};
    o[4] = {oe, 800'b0};
  end

  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(5)) u_a (
    .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_RHO_INV_EN
    .inv(ivs[0]),
`endif
    .in_valid(iv[0]), .in_ready(ir[0]), .in_state(si[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(oa));
  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(25)) u_b (
    .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_RHO_INV_EN
    .inv(ivs[1]),
`endif
    .in_valid(iv[1]), .in_ready(ir[1]), .in_state(si[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ob));
  keccak_rho_seq #(.LANE_W(64), .LANES_PER_CYC(1)) u_c (
    .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_RHO_INV_EN
    .inv(ivs[2]),
`endif
    .in_valid(iv[2]), .in_ready(ir[2]), .in_state(si[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(oc));
  keccak_rho_seq #(.LANE_W(8), .LANES_PER_CYC(5)) u_d (
    .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_RHO_INV_EN
    .inv(ivs[3]),
`endif
    .in_valid(iv[3]), .in_ready(ir[3]), .in_state(si[3][0:199]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_state(od));
  keccak_rho_seq #(.LANE_W(32), .LANES_PER_CYC(5)) u_e (
    .clk(clk), .rst_n(rst_n),
`ifdef KECCAK_RHO_INV_EN
    .inv(ivs[4]),
`endif
    .in_valid(iv[4]), .in_ready(ir[4]), .in_state(si[4][0:799]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_state(oe));

  // Reference: per-bit rho definition, zero above 25*w
  function automatic logic [0:1599] rho_model(input logic [0:1599] s, input int w, input bit inv);
    logic [0:1599] r;
    int rr;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      rr = R[i] % w;
      for (int j = 0; j < w; j++)
        r[i*w+j] = s[i*w + (inv ? (j + rr) % w : (j + 5*w - rr) % w)];
    end
    return r;
  endfunction

  function automatic logic [0:1599] rnd(input int w);
    logic [0:1599] r;
    r = '0;
    for (int b = 0; b < 25*w; b++) r[b] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic xfer(input int d, input logic [0:1599] s, input bit inv, input bit stall,
                      input string tag, output logic [0:1599] res);
    logic [0:1599] ex;
    logic [63:0] g, e;
    int n, bad;
    ex = rho_model(s, WD[d], inv);
    @(negedge clk);
    iv[d] = 1'b1;
    si[d] = s;
    ivs[d] = inv;
    ordy[d] = 1'b1;
    #1;
    n = 0;
    while (ir[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (ir[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready at offer: got %b expected 1", tag, ir[d]);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    si[d] = rnd(WD[d]);
    ivs[d] = ~inv;
    ordy[d] = 1'b0;
    checks++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s after accept: out_valid %b in_ready %b expected 0 0", tag, ov[d], ir[d]);
    end
    n = 0;
    while (ov[d] !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 25 / LP[d] || ov[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", tag, n, 25 / LP[d]);
    end
    checks++;
    if (o[d] !== ex) begin
      errors++;
      bad = 0;
      for (int b = 1599; b >= 0; b--) if (o[d][b] !== ex[b]) bad = b;
      bad = bad / WD[d];
      g = '0;
      e = '0;
      for (int j = 0; j < WD[d]; j++) begin
        g = {g[62:0], o[d][bad*WD[d]+j]};
        e = {e[62:0], ex[bad*WD[d]+j]};
      end
      $display("FAIL %s out_state lane %0d: got %h expected %h", tag, bad, g, e);
    end
    if (stall)
      for (int c = 0; c < 7; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || o[d] !== ex) begin
          errors++;
          $display("FAIL %s stall cycle %0d: out_valid %b in_ready %b data_ok %b expected 1 0 1",
                   tag, c, ov[d], ir[d], o[d] === ex);
        end
      end
    res = o[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 5; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
      ivs[d] = 1'b0;
      si[d] = '0;
    end
    #3;
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || o[d] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: out_valid %b in_ready %b state_zero %b expected 0 1 1",
                 d, ov[d], ir[d], o[d] === '0);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_bit();
    logic [0:1599] s, ex, res;
    s = '0;
    s[64] = 1'b1;
    ex = '0;
    ex[65] = 1'b1;
    xfer(0, s, 1'b0, 1'b0, "lane1_bit0", res);
    checks++;
    if (res !== ex) begin
      errors++;
      $display("FAIL lane1_bit0 const: got bit65=%b ones=%0d expected bit65=1 ones=1", res[65], $countones(res));
    end
    s = '0;
    s[128] = 1'b1;
    ex = '0;
    ex[190] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      xfer(d, s, 1'b0, 1'b0, "lane2_r62", res);
      checks++;
      if (res !== ex) begin
        errors++;
        $display("FAIL lane2_r62 dut%0d const: got bit190=%b ones=%0d expected bit190=1 ones=1",
                 d, res[190], $countones(res));
      end
    end
  endtask

  task automatic test_w8();
    logic [0:1599] s, res;
    s = '0;
    s[8 +: 8] = 8'h80;
    s[40 +: 8] = 8'h80;
    xfer(3, s, 1'b0, 1'b0, "w8", res);
    checks++;
    if (res[8 +: 8] !== 8'h40 || res[40 +: 8] !== 8'h08) begin
      errors++;
      $display("FAIL w8 lanes: got lane1 %h lane5 %h expected 40 08", res[8 +: 8], res[40 +: 8]);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:1599] res;
    int order [5] = '{0, 4, 3, 1, 2};
    for (int t = 0; t < 5; t++)
      for (int n = 0; n < 3; n++)
        xfer(order[t], rnd(WD[order[t]]), 1'b0, 1'b1, $sformatf("rand_dut%0d_%0d", order[t], n), res);
  endtask

  task automatic test_reset_mid_rot();
    logic [0:1599] res;
    @(negedge clk);
    iv[0] = 1'b1;
    si[0] = rnd(64);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || o[0] !== '0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rot: out_valid %b state_zero %b in_ready %b expected 0 1 1",
               ov[0], o[0] === '0, ir[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, rnd(64), 1'b0, 1'b0, "after_reset", res);
  endtask

`ifdef KECCAK_RHO_INV_EN
  task automatic test_inverse();
    logic [0:1599] s, r1, r2;
    int ds [2] = '{0, 4};
    for (int t = 0; t < 2; t++)
      for (int n = 0; n < 2; n++) begin
        s = rnd(WD[ds[t]]);
        xfer(ds[t], s, 1'b0, 1'b0, "inv_fwd", r1);
        xfer(ds[t], r1, 1'b1, 1'b0, "inv_back", r2);
        checks++;
        if (r2 !== s) begin
          errors++;
          $display("FAIL inv_roundtrip dut%0d: got lane0 %h expected %h", ds[t], r2[0 +: 32], s[0 +: 32]);
        end
      end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_bit();
    test_w8();
    test_back_to_back();
    test_reset_mid_rot();
`ifdef KECCAK_RHO_INV_EN
    test_inverse();
`endif
    @(negedge clk);
    for (int d = 0; d < 5; d++) ordy[d] = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
